// File: rtl/inst_mem_responder_pkg.sv
// Shared types and defaults for the fetch-side memory responders.
// Provides the response bundle carried through the latency pipeline.
package inst_mem_responder_pkg;

    localparam int IMEM_ADDR_W  = 64;
    localparam int IMEM_INST_W  = 32;
    localparam int DATA_W       = 32;
    localparam int IMEM_DEPTH   = 1024;
    localparam int IMEM_LATENCY = 10;

    localparam logic [IMEM_INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic                   valid;
        logic [IMEM_INST_W-1:0] data;
        logic                   err;
    } imem_rsp_t;

endpackage

// File: rtl/inst_mem_responder_resp_delay_line.sv
// resp_delay_line: LATENCY-deep registered shift chain of imem_rsp_t.
// Ports: i_clk, i_rst_n (async clear), i_rsp (stage-1 input), o_rsp (last stage).
module resp_delay_line
    import inst_mem_responder_pkg::*;
#(
    parameter int LATENCY = IMEM_LATENCY
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  imem_rsp_t i_rsp,
    output imem_rsp_t o_rsp
);

    imem_rsp_t stage_q [LATENCY];

    // No stall: every stage advances every cycle, so an empty slot
    // (all zero) flows through and keeps the outputs clean when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_rsp = stage_q[LATENCY-1];

endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: word-addressed instruction array with fixed-latency,
// fully pipelined responses and a backdoor write port for program loading.
// Ports: i_clk, i_rst_n; request i_valid_addr/i_addr; backdoor
// i_wen/i_waddr/i_wdata; response o_valid/o_inst/o_addr_err.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int INST_W  = IMEM_INST_W,
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int LATENCY = IMEM_LATENCY
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid_addr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [INST_W-1:0] i_wdata,
    output logic              o_valid,
    output logic [INST_W-1:0] o_inst,
    output logic              o_addr_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [INST_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic             r_mis;
    logic             r_oor;
    logic             w_oor;
    logic             unused_waddr;

    imem_rsp_t req;
    imem_rsp_t rsp;

    assign ridx  = i_addr[IDX_W+1:2];
    assign r_mis = |i_addr[1:0];
    assign r_oor = |i_addr[ADDR_W-1:IDX_W+2];

    assign widx  = i_waddr[IDX_W+1:2];
    assign w_oor = |i_waddr[ADDR_W-1:IDX_W+2];

    // Byte-lane bits of the backdoor address carry no meaning.
    assign unused_waddr = ^i_waddr[1:0];

    // Backdoor write. Non-blocking update means a same-edge read of
    // the same word still sees the old contents.
    always_ff @(posedge i_clk) begin
        if (i_wen && !w_oor) begin
            mem[widx] <= i_wdata;
        end
    end

    // Stage-1 input: read the array now, register in the delay line.
    // Faulting requests carry zero data so nothing stale leaks out.
    always_comb begin
        req = '0;
        if (i_valid_addr) begin
            req.valid = 1'b1;
            req.err   = r_mis | r_oor;
            req.data  = (r_mis | r_oor) ? '0 : mem[ridx];
        end
    end

    resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rsp   (req),
        .o_rsp   (rsp)
    );

    assign o_valid    = rsp.valid;
    assign o_inst     = rsp.data;
    assign o_addr_err = rsp.err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder at LATENCY=10 and LATENCY=1.
// Both instances share stimulus; each scenario checks one of them.
module tb_inst_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        valid_addr;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] waddr;
    logic [31:0] wdata;

    logic        v10;
    logic [31:0] inst10;
    logic        err10;
    logic        v1;
    logic [31:0] inst1;
    logic        err1;

    int n_cmp;
    int n_bad;

    logic [31:0] prog [4];

    inst_mem_responder #(
        .ADDR_W  (64),
        .INST_W  (32),
        .DEPTH   (1024),
        .LATENCY (10)
    ) dut10 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid_addr (valid_addr),
        .i_addr       (addr),
        .i_wen        (wen),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .o_valid      (v10),
        .o_inst       (inst10),
        .o_addr_err   (err10)
    );

    inst_mem_responder #(
        .ADDR_W  (64),
        .INST_W  (32),
        .DEPTH   (1024),
        .LATENCY (1)
    ) dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid_addr (valid_addr),
        .i_addr       (addr),
        .i_wen        (wen),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .o_valid      (v1),
        .o_inst       (inst1),
        .o_addr_err   (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bd_write(input logic [63:0] a, input logic [31:0] d);
        @(negedge clk);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({v10, inst10, err10} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_l10: got v=%b i=%h e=%b want 0/0/0",
                     v10, inst10, err10);
        end
        n_cmp++;
        if ({v1, inst1, err1} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_l1: got v=%b i=%h e=%b want 0/0/0",
                     v1, inst1, err1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        for (int i = 0; i < 4; i++) begin
            bd_write(64'(i * 4), prog[i]);
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        logic        ev;
        logic [31:0] ei;
        valid_addr = 1'b1;
        addr       = 64'd8;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin
                valid_addr = 1'b0;
                addr       = 64'hFFFF;
            end
            ev = (n == 10);
            ei = ev ? 32'h0020_0113 : 32'h0;
            n_cmp++;
            if ({v10, inst10, err10} !== {ev, ei, 1'b0}) begin
                n_bad++;
                $display("FAIL single n=%0d: got v=%b i=%h e=%b want %b/%h/0",
                         n, v10, inst10, err10, ev, ei);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        ev;
        logic [31:0] ei;
        valid_addr = 1'b1;
        addr       = 64'd0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n <= 3) begin
                addr = 64'(n * 4);
            end else begin
                valid_addr = 1'b0;
            end
            ev = (n >= 10 && n <= 13);
            ei = ev ? prog[n-10] : 32'h0;
            n_cmp++;
            if ({v10, inst10, err10} !== {ev, ei, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b n=%0d: got v=%b i=%h e=%b want %b/%h/0",
                         n, v10, inst10, err10, ev, ei);
            end
        end
    endtask

    task automatic test_addr_err;
        logic ev;
        valid_addr = 1'b1;
        addr       = 64'd6;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin
                addr = 64'd4096;
            end else begin
                valid_addr = 1'b0;
            end
            ev = (n == 10 || n == 11);
            n_cmp++;
            if ({v10, inst10, err10} !== {ev, 32'h0, ev}) begin
                n_bad++;
                $display("FAIL addr_err n=%0d: got v=%b i=%h e=%b want %b/0/%b",
                         n, v10, inst10, err10, ev, ev);
            end
        end
    endtask

    task automatic test_rbw;
        logic        ev;
        logic [31:0] ei;
        valid_addr = 1'b1;
        addr       = 64'd4;
        wen        = 1'b1;
        waddr      = 64'd4;
        wdata      = 32'hDEAD_BEEF;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            wen = 1'b0;
            if (n != 1) begin
                valid_addr = 1'b0;
            end
            ev = (n == 10 || n == 11);
            ei = (n == 10) ? 32'h0010_0093 :
                 (n == 11) ? 32'hDEAD_BEEF : 32'h0;
            n_cmp++;
            if ({v10, inst10, err10} !== {ev, ei, 1'b0}) begin
                n_bad++;
                $display("FAIL rbw n=%0d: got v=%b i=%h e=%b want %b/%h/0",
                         n, v10, inst10, err10, ev, ei);
            end
        end
    endtask

    task automatic test_wr_addr;
        logic        ev;
        logic [31:0] ei;
        bd_write(64'd4096, 32'hBAD0_BAD0);
        bd_write(64'd14, 32'h1234_5678);
        @(negedge clk);
        valid_addr = 1'b1;
        addr       = 64'd0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin
                addr = 64'd12;
            end else begin
                valid_addr = 1'b0;
            end
            ev = (n == 10 || n == 11);
            ei = (n == 10) ? 32'h0000_0013 :
                 (n == 11) ? 32'h1234_5678 : 32'h0;
            n_cmp++;
            if ({v10, inst10, err10} !== {ev, ei, 1'b0}) begin
                n_bad++;
                $display("FAIL wr_addr n=%0d: got v=%b i=%h e=%b want %b/%h/0",
                         n, v10, inst10, err10, ev, ei);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic        ev;
        logic [31:0] ei;
        valid_addr = 1'b1;
        addr       = 64'd0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n <= 2) begin
                addr = 64'(n * 4);
            end else begin
                valid_addr = 1'b0;
            end
            if (n == 5) rst_n = 1'b0;
            if (n == 7) rst_n = 1'b1;
            n_cmp++;
            if ({v10, inst10, err10} !== 34'd0) begin
                n_bad++;
                $display("FAIL mid_reset n=%0d: got v=%b i=%h e=%b want 0/0/0",
                         n, v10, inst10, err10);
            end
        end
        valid_addr = 1'b1;
        addr       = 64'd0;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            valid_addr = 1'b0;
            ev = (n == 10);
            ei = ev ? 32'h0000_0013 : 32'h0;
            n_cmp++;
            if ({v10, inst10, err10} !== {ev, ei, 1'b0}) begin
                n_bad++;
                $display("FAIL post_reset n=%0d: got v=%b i=%h e=%b want %b/%h/0",
                         n, v10, inst10, err10, ev, ei);
            end
        end
    endtask

    task automatic test_lat1;
        logic        ev;
        logic [31:0] ei;
        valid_addr = 1'b1;
        addr       = 64'd0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n <= 3) begin
                addr = 64'(n * 4);
            end else if (n == 4) begin
                addr = 64'd6;
            end else begin
                valid_addr = 1'b0;
            end
            ev = (n <= 5);
            ei = (n <= 4) ? prog[n-1] : 32'h0;
            n_cmp++;
            if ({v1, inst1, err1} !== {ev, ei, (n == 5)}) begin
                n_bad++;
                $display("FAIL lat1 n=%0d: got v=%b i=%h e=%b want %b/%h/%b",
                         n, v1, inst1, err1, ev, ei, (n == 5));
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        prog[0]    = 32'h0000_0013;
        prog[1]    = 32'h0010_0093;
        prog[2]    = 32'h0020_0113;
        prog[3]    = 32'h0030_0193;
        rst_n      = 1'b0;
        valid_addr = 1'b0;
        addr       = '0;
        wen        = 1'b0;
        waddr      = '0;
        wdata      = '0;
        test_reset;
        test_load;
        test_single;
        test_back_to_back;
        test_addr_err;
        test_rbw;
        bd_write(64'd4, 32'h0010_0093);
        bd_write(64'd12, 32'h0030_0193);
        test_wr_addr;
        bd_write(64'd12, 32'h0030_0193);
        test_mid_reset;
        test_lat1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Instruction-memory responder on the fetch-side memory interface. Accepts single-cycle address requests from the fetch stage, reads a word-addressed instruction array, and returns the instruction with a fixed, parameterised latency. Fully pipelined, so a new request may be accepted every cycle. Includes a backdoor write port for program loading by the bench or boot logic.

Parameters:
ADDR_W, 64, request address width (byte address)
INST_W, 32, instruction word width
DEPTH, 1024, number of INST_W words in the array (power of two, >= 2)
LATENCY, 10, cycles from request acceptance to response (>= 1)

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_valid_addr  input  1  request strobe from fetch; one request per high cycle
i_addr  input  ADDR_W  request byte address, sampled when i_valid_addr=1
i_wen  input  1  backdoor write enable
i_waddr  input  ADDR_W  backdoor write byte address (word-aligned)
i_wdata  input  INST_W  backdoor write data
o_valid  output  1  response strobe, high exactly one cycle per accepted request
o_inst  output  INST_W  instruction data, meaningful only when o_valid=1, else 0
o_addr_err  output  1  high with o_valid when the request was misaligned or out of range

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_inst=0, o_addr_err=0, and every pipeline stage valid bit is cleared. Array contents are not reset.
- Reset asserted mid-operation: all in-flight requests are dropped with no response. After release, the first response appears only for requests accepted after release.
- Index: idx = i_addr[log2(DEPTH)+1 : 2].
- Range check: request is in range iff i_addr[ADDR_W-1 : log2(DEPTH)+2] == 0.
- Misaligned: i_addr[1:0] != 0.
- Acceptance cycle T (rising edge with i_valid_addr=1):
  - Array is read at idx.
  - Stage 1 captures {valid=1, data, err}, with err = misaligned | out_of_range.
  - If err=1, the captured data is forced to 0.
- Latency: the response for a request accepted at edge T is presented after edge T+LATENCY-1, and the outputs are registered.
  - LATENCY=1: o_valid is high in the cycle immediately after the request cycle.
- Pipeline: a shift chain of LATENCY stages, each holding {valid, data, err}.
  - Advances every cycle; there is no stall or backpressure.
  - Back-to-back requests produce back-to-back responses in request order.
- Idle stages: outputs are o_valid=0, o_inst=0, o_addr_err=0; never hold stale data.
- Backdoor write: on an edge with i_wen=1, array[waddr idx] <= i_wdata.
  - i_waddr[1:0] is ignored.
  - An out-of-range i_waddr is ignored; no array change.
- Same-edge read and write to the same idx: the read returns the OLD contents (read-before-write).
- Write and request on different indices in the same cycle: both proceed independently.
- i_addr is ignored when i_valid_addr=0.
- No internal FSM beyond the pipeline; occupancy is implied by the stage valid bits.

Decomposition:
- Shared package:
  - ADDR_W/INST_W/DATA_W defaults.
  - IMEM_DEPTH, IMEM_LATENCY constants.
  - Typedef imem_rsp_t {valid, data[INST_W], err}.
  - NOP_INST constant (32'h0000_0013) for the bench.
- One natural sub-module: resp_delay_line.
  - A LATENCY-deep registered shift chain of imem_rsp_t with async active-low clear.
  - Reused later for the data-memory responder.
- The array plus address checks stay in inst_mem_responder.

Test Plan:
- Load words 0..3 = 32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193 via backdoor; request i_addr=8 at cycle T -> o_valid=1, o_inst=32'h0020_0113, o_addr_err=0 exactly in cycle T+10, o_valid=0 otherwise.
- Requests on 4 consecutive cycles, addr 0,4,8,12 -> 4 consecutive o_valid cycles starting T+10 with data 0013,00100093,00200113,00300193 in order.
- Request i_addr=6 (misaligned) and i_addr=4096 (out of range, DEPTH=1024) -> each returns o_valid=1, o_inst=0, o_addr_err=1 at +10 cycles.
- Same cycle: i_wen=1, i_waddr=4, i_wdata=32'hDEAD_BEEF and request addr 4 -> response 32'h0010_0093; repeat request next cycle -> 32'hDEAD_BEEF.
- Issue 3 requests, assert i_rst_n=0 for 2 cycles at T+5, release -> no o_valid for any of them; a post-release request at addr 0 returns 32'h0000_0013 with correct latency, and array contents are intact.
- Rerun with LATENCY=1 -> request at cycle T responds in cycle T+1; continuous requests yield continuous responses.
